// File: rtl/seed.sv
// Seed-pattern entry for the 8x8 Game of Life: each rising edge of `next`
// commits the switch pattern `in` into the next row; HEX0 shows the row being entered.
module seed (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      in,
  input  logic            next,
  output logic [7:0][7:0] out,
  output logic [6:0]      HEX0
);

  typedef enum logic {ENTRY, DONE} state_t;

  state_t     state, state_nx;
  logic [2:0] row, row_nx;
  logic       next_d;
  logic       commit;
  logic       write;

  assign commit = next & ~next_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ENTRY;
      row    <= '0;
      next_d <= 1'b0;
      out    <= '0;
    end else begin
      state  <= state_nx;
      row    <= row_nx;
      next_d <= next;
      if (write)
        out[row] <= in;
    end
  end

  always_comb begin
    state_nx = state;
    row_nx   = row;
    write    = 1'b0;
    HEX0     = 7'b0111111;
    unique case (state)
      ENTRY: begin
        if (commit) begin
          write = 1'b1;
          if (row == 3'd7)
            state_nx = DONE;
          else
            row_nx = row + 3'd1;
        end
        unique case (row)
          3'd0: HEX0 = 7'b1000000;
          3'd1: HEX0 = 7'b1111001;
          3'd2: HEX0 = 7'b0100100;
          3'd3: HEX0 = 7'b0110000;
          3'd4: HEX0 = 7'b0011001;
          3'd5: HEX0 = 7'b0010010;
          3'd6: HEX0 = 7'b0000010;
          3'd7: HEX0 = 7'b1111000;
          default: HEX0 = 7'b0111111;
        endcase
      end
      DONE: HEX0 = 7'b0111111;
      default: state_nx = ENTRY;
    endcase
  end

endmodule

// File: tb/tb_seed.sv
// Directed bench for seed: hand-computed vectors, immediate assertions at each check.
module tb_seed;

  logic            clk;
  logic            reset;
  logic [7:0]      in;
  logic            next;
  logic [7:0][7:0] out;
  logic [6:0]      HEX0;

  int unsigned vectors;
  int unsigned miscompares;

  seed dut (
    .clk  (clk),
    .reset(reset),
    .in   (in),
    .next (next),
    .out  (out),
    .HEX0 (HEX0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic pulse(input logic [7:0] pat);
    in   = pat;
    next = 1'b1;
    tick();
    next = 1'b0;
    tick();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset = 1'b1;
    in    = 8'h00;
    next  = 1'b0;

    #12;
    check("reset_out", out, 64'h0);
    check("reset_hex", {57'h0, HEX0}, {57'h0, 7'b1000000});
    tick();
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      in = (i % 2 == 0) ? 8'hFF : 8'h00;
      tick();
    end
    check("in_only_out", out, 64'h0);
    check("in_only_hex", {57'h0, HEX0}, {57'h0, 7'b1000000});

    pulse(8'hA5);
    check("pulse_out", out, 64'h0000_0000_0000_00A5);
    check("pulse_hex", {57'h0, HEX0}, {57'h0, 7'b1111001});

    in   = 8'h3C;
    next = 1'b1;
    repeat (20) tick();
    next = 1'b0;
    tick();
    check("hold_out", out, 64'h0000_0000_0000_3CA5);
    check("hold_hex", {57'h0, HEX0}, {57'h0, 7'b0100100});

    reset = 1'b1;
    #2;
    reset = 1'b0;
    tick();
    for (int r = 0; r < 8; r++) begin
      pulse(8'h01 << r);
      if (r == 3) check("row3_hex", {57'h0, HEX0}, {57'h0, 7'b0011001});
      if (r == 6) check("row6_hex", {57'h0, HEX0}, {57'h0, 7'b1111000});
    end
    check("full_out", out, 64'h8040_2010_0804_0201);
    check("done_hex", {57'h0, HEX0}, {57'h0, 7'b0111111});
    pulse(8'hFF);
    pulse(8'hFF);
    check("done_frozen", out, 64'h8040_2010_0804_0201);
    check("done_hex2", {57'h0, HEX0}, {57'h0, 7'b0111111});

    reset = 1'b1;
    #2;
    reset = 1'b0;
    tick();
    pulse(8'h11);
    pulse(8'h22);
    pulse(8'h33);
    check("three_out", out, 64'h0000_0000_0033_2211);
    #2;
    reset = 1'b1;
    #1;
    check("async_out", out, 64'h0);
    check("async_hex", {57'h0, HEX0}, {57'h0, 7'b1000000});
    #1;
    reset = 1'b0;
    tick();
    pulse(8'h77);
    check("after_rst_out", out, 64'h0000_0000_0000_0077);
    check("after_rst_hex", {57'h0, HEX0}, {57'h0, 7'b1111001});

    in    = 8'hFF;
    reset = 1'b1;
    next  = 1'b1;
    tick();
    reset = 1'b0;
    next  = 1'b0;
    tick();
    check("rst_wins_out", out, 64'h0);
    check("rst_wins_hex", {57'h0, HEX0}, {57'h0, 7'b1000000});
    pulse(8'h5A);
    check("rst_wins_row0", out, 64'h0000_0000_0000_005A);

    reset = 1'b1;
    in    = 8'hC3;
    next  = 1'b1;
    #2;
    reset = 1'b0;
    tick();
    next = 1'b0;
    tick();
    check("release_high_out", out, 64'h0000_0000_0000_00C3);
    check("release_high_hex", {57'h0, HEX0}, {57'h0, 7'b1111001});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
